// File: rtl/mult_job_sequencer_pkg.sv
// mult_job_sequencer_pkg: shared state encoding, operand/product widths and default watchdog limit
package mult_job_sequencer_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam int TIMEOUT_DEF = 31;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_RUN = 2'd2, ST_HOLD = 2'd3} state_t;
endpackage

// File: rtl/mult_job_sequencer_if.sv
// mult_job_sequencer_if: job input, multiplier link and result output of the sequencer
// master = sequencer side, slave = upstream producer / multiplier / consumer side
interface mult_job_sequencer_if #(parameter int AW = 2);
  import mult_job_sequencer_pkg::*;
  logic in_valid, in_ready;
  logic [OP_W-1:0] in_a, in_b;
  logic mult_start, mult_done, mult_rst_n;
  logic [OP_W-1:0] mult_a, mult_b;
  logic [PROD_W-1:0] mult_product;
  logic out_valid, out_ready, out_err, busy;
  logic [PROD_W-1:0] out_product;
  logic [AW:0] fifo_count;
  modport master (
    input in_valid, in_a, in_b, mult_done, mult_product, out_ready,
    output in_ready, mult_start, mult_a, mult_b, mult_rst_n, out_valid, out_product, out_err, busy, fifo_count
  );
  modport slave (
    output in_valid, in_a, in_b, mult_done, mult_product, out_ready,
    input in_ready, mult_start, mult_a, mult_b, mult_rst_n, out_valid, out_product, out_err, busy, fifo_count
  );
endinterface

// File: rtl/mult_job_sequencer_sync_fifo_op.sv
// sync_fifo_op: DEPTH x W synchronous FIFO with occupancy count and show-ahead head output
// ports: clk, rst (async active-low), push/wdata, pop/rdata, count
module sync_fifo_op import mult_job_sequencer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter int W = PROD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: queues operand pairs and drives a level-start Booth multiplier one job at a time
// ports: clk, rst (async active-low), bus (mult_job_sequencer_if.master: input job, multiplier link, result)
// optional MULT_TIMEOUT_EN: watchdog aborts a job after TIMEOUT RUN cycles with an error result
module mult_job_sequencer import mult_job_sequencer_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW = 2
`ifdef MULT_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input logic clk,
  input logic rst,
  mult_job_sequencer_if.master bus
);
  logic push, pop;
  logic [PROD_W-1:0] head;
  logic [AW:0] count;
  state_t state_q, state_d;
  logic start_q, start_d, ov_q, ov_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] prod_q, prod_d;
`ifdef MULT_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic err_q, err_d, mrst_q, mrst_d;
  assign bus.mult_rst_n = mrst_q;
  assign bus.out_err = err_q;
`else
  assign bus.mult_rst_n = 1'b1;
  assign bus.out_err = 1'b0;
`endif
  assign push = bus.in_valid && bus.in_ready;
  sync_fifo_op #(.DEPTH(DEPTH), .AW(AW), .W(PROD_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wdata({bus.in_a, bus.in_b}), .rdata(head), .count(count)
  );
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    a_d = a_q;
    b_d = b_q;
    prod_d = prod_q;
    ov_d = ov_q && !bus.out_ready;
    pop = 1'b0;
`ifdef MULT_TIMEOUT_EN
    err_d = err_q;
    mrst_d = 1'b1;
    wd_d = wd_q;
`endif
    case (state_q)
      // launch only into a free result slot, so capture never meets a handshake
      ST_IDLE: if (count != '0 && (!ov_q || bus.out_ready)) begin
        pop = 1'b1;
        {a_d, b_d} = head;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        start_d = 1'b1;
        state_d = ST_RUN;
`ifdef MULT_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      // start must fall on the done edge or the multiplier relaunches on the same operands
      ST_RUN: if (bus.mult_done) begin
        start_d = 1'b0;
        prod_d = bus.mult_product;
        ov_d = 1'b1;
        state_d = ST_HOLD;
`ifdef MULT_TIMEOUT_EN
        err_d = 1'b0;
      end else if (wd_q == WDW'(TIMEOUT - 1)) begin
        start_d = 1'b0;
        mrst_d = 1'b0;
        prod_d = '0;
        ov_d = 1'b1;
        err_d = 1'b1;
        state_d = ST_HOLD;
      end else begin
        wd_d = wd_q + WDW'(1);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      prod_q <= '0;
      ov_q <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      wd_q <= '0;
      err_q <= 1'b0;
      mrst_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q <= a_d;
      b_q <= b_d;
      prod_q <= prod_d;
      ov_q <= ov_d;
`ifdef MULT_TIMEOUT_EN
      wd_q <= wd_d;
      err_q <= err_d;
      mrst_q <= mrst_d;
`endif
    end
  assign bus.in_ready = count != (AW+1)'(DEPTH);
  assign bus.mult_start = start_q;
  assign bus.mult_a = a_q;
  assign bus.mult_b = b_q;
  assign bus.out_valid = ov_q;
  assign bus.out_product = prod_q;
  assign bus.busy = state_q != ST_IDLE || count != '0;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb_mult_job_sequencer: directed and randomized checks of the job sequencer against a queue-based model
module tb_mult_job_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mult_job_sequencer_if #(.AW(2)) bus();
  mult_job_sequencer #(.DEPTH(4), .AW(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, starts = 0, npush = 0, nres = 0, lat = 20;
  bit hang = 0, spur = 0, saw_full = 0;
  logic [15:0] jobs[$];
  logic [16:0] exp_q[$];
  bit prev_start, prev_done, m_busy;
  logic [15:0] held;
  int m_cnt;
  logic [7:0] m_a, m_b;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic fail(input string n);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", n);
  endtask

  // bench multiplier: level start, fixed latency, one-cycle done; restarts if start stays high
  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 0;
      bus.mult_done = 0;
      bus.mult_product = 0;
    end else if (bus.mult_done) begin
      bus.mult_done = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (!bus.mult_rst_n) m_busy = 0;
      else if (!hang) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          bus.mult_done = 1;
          bus.mult_product = smul(m_a, m_b);
        end
      end
    end else if (bus.mult_start && bus.mult_rst_n) begin
      m_busy = 1;
      m_cnt = lat;
      m_a = bus.mult_a;
      m_b = bus.mult_b;
      starts++;
    end else if (spur) begin
      spur = 0;
      bus.mult_done = 1;
      bus.mult_product = 16'hDEAD;
    end
  end

  // per-cycle compare against the job/result queues
  always @(posedge clk) begin
    if (!rst) begin
      jobs.delete();
      exp_q.delete();
      prev_start = 0;
      prev_done = 0;
    end else begin
      if (prev_done) chk("start_drop_on_done", bus.mult_start, 0);
      if (bus.mult_start && !prev_start) begin
        if (jobs.size() == 0) fail("launch_without_job");
        else begin
          chk("launch_ops", {bus.mult_a, bus.mult_b}, jobs[0]);
          void'(jobs.pop_front());
        end
        chk("launch_slot_free", bus.out_valid, 0);
      end else if (bus.mult_start && prev_start) chk("ops_frozen", {bus.mult_a, bus.mult_b}, held);
      chk("in_ready_rule", bus.in_ready, bus.fifo_count != 3'd4);
      if (bus.in_valid && bus.in_ready) begin
        jobs.push_back({bus.in_a, bus.in_b});
        exp_q.push_back({hang, hang ? 16'h0 : smul(bus.in_a, bus.in_b)});
        npush++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail("result_without_job");
        else begin
          chk("result", {bus.out_err, bus.out_product}, exp_q[0]);
          void'(exp_q.pop_front());
        end
        nres++;
      end
      if (!bus.in_ready && bus.fifo_count == 3'd4) saw_full = 1;
      prev_start = bus.mult_start;
      prev_done = bus.mult_done && bus.mult_start;
      held = {bus.mult_a, bus.mult_b};
    end
  end

  task automatic push1(input logic [7:0] a, input logic [7:0] b);
    int g = 0;
    while (!bus.in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) fail("push_wait");
    bus.in_valid = 1;
    bus.in_a = a;
    bus.in_b = b;
    @(negedge clk);
    bus.in_valid = 0;
  endtask

  task automatic wait_out();
    int g = 0;
    while (!bus.out_valid && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) fail("out_valid_wait");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, s0, n0;
    bus.in_valid = 0;
    bus.in_a = 0;
    bus.in_b = 0;
    bus.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_start", bus.mult_start, 0);
    chk("rst_ops", {bus.mult_a, bus.mult_b}, 0);
    chk("rst_mrst_n", bus.mult_rst_n, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_product", bus.out_product, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1;
    @(negedge clk);
    spur = 1;
    repeat (4) @(negedge clk);
    chk("spurious_done_ignored", bus.out_valid, 0);
    chk("spurious_no_start", starts, 0);
    push1(8'd3, 8'd5);
    @(negedge clk);
    chk("latency_pre", bus.mult_start, 0);
    @(negedge clk);
    chk("latency_start", bus.mult_start, 1);
    wait_out();
    chk("p_3x5", bus.out_product, 16'h000F);
    chk("e_3x5", bus.out_err, 0);
    @(negedge clk);
    push1(8'hFE, 8'd7);
    wait_out();
    chk("p_m2x7", bus.out_product, 16'hFFF2);
    @(negedge clk);
    bus.out_ready = 0;
    push1(8'd3, 8'd3);
    push1(8'd2, 8'd9);
    wait_out();
    chk("p_3x3", bus.out_product, 16'h0009);
    s0 = starts;
    repeat (40) @(negedge clk);
    chk("stall_no_launch", starts, s0);
    chk("stall_hold_prod", bus.out_product, 16'h0009);
    chk("stall_hold_valid", bus.out_valid, 1);
    chk("stall_count", bus.fifo_count, 1);
    bus.out_ready = 1;
    @(negedge clk);
    wait_out();
    chk("p_2x9", bus.out_product, 16'h0012);
    @(negedge clk);
    saw_full = 0;
    n0 = nres;
    for (int i = 0; i < 5; i++) push1(8'(i + 1), 8'(8'hF0 + i));
    g = 0;
    while (nres < n0 + 5 && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk("five_results", nres - n0, 5);
    chk("five_saw_full", saw_full, 1);
    repeat (3) @(negedge clk);
    chk("five_count_empty", bus.fifo_count, 0);
    chk("five_idle", bus.busy, 0);
    push1(8'd7, 8'd7);
    g = 0;
    while (!bus.mult_start && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (9) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("midrun_rst_start", bus.mult_start, 0);
    chk("midrun_rst_valid", bus.out_valid, 0);
    chk("midrun_rst_count", bus.fifo_count, 0);
    chk("midrun_rst_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    push1(8'd4, 8'd4);
    wait_out();
    chk("p_4x4", bus.out_product, 16'h0010);
    @(negedge clk);
    n0 = npush + 40;
    g = 0;
    while (g < 20000) begin
      @(negedge clk);
      g++;
      if (npush >= n0) break;
      bus.in_valid = $urandom_range(0, 2) != 0;
      bus.in_a = 8'($urandom);
      bus.in_b = 8'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      lat = $urandom_range(1, 6);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    g = 0;
    while ((exp_q.size() != 0 || bus.busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("rand_pushed", npush >= n0, 1);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_count", bus.fifo_count, 0);
    lat = 20;
`ifdef MULT_TIMEOUT_EN
    hang = 1;
    push1(8'd5, 8'd5);
    g = 0;
    while (!bus.mult_start && g < 20) begin
      @(negedge clk);
      g++;
    end
    g = 0;
    while (bus.mult_start && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("to_run_cycles", g, 31);
    chk("to_mrst_low", bus.mult_rst_n, 0);
    chk("to_valid", bus.out_valid, 1);
    chk("to_err", bus.out_err, 1);
    chk("to_product", bus.out_product, 0);
    hang = 0;
    @(negedge clk);
    chk("to_mrst_release", bus.mult_rst_n, 1);
    push1(8'd6, 8'd7);
    wait_out();
    chk("to_next_product", bus.out_product, 16'h002A);
    chk("to_next_err", bus.out_err, 0);
    @(negedge clk);
`endif
    repeat (5) @(negedge clk);
    chk("final_idle", bus.busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
- Upstream job front-end for the 8x8 signed Booth multiplier.
- Buffers incoming operand pairs in a small FIFO and drives the multiplier's level-sensitive start input. It holds A/B stable for the whole operation, captures the 16-bit product on the done pulse, and presents it on a valid/ready output.
- Ensures start is dropped in time so the multiplier never auto-restarts on a stale operand pair.

Parameters:
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- AW, 2, FIFO pointer width; log2(DEPTH).
- TIMEOUT, 31, watchdog limit in cycles from start assertion; used only with the optional feature.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full; transfer when in_valid && in_ready.
- in_a  in  8  multiplicand, two's complement.
- in_b  in  8  multiplier, two's complement.
- mult_start  out  1  level start to the multiplier; registered.
- mult_a  out  8  registered operand A to the multiplier.
- mult_b  out  8  registered operand B to the multiplier.
- mult_done  in  1  one-cycle done pulse from the multiplier.
- mult_product  in  16  multiplier product; valid while mult_done is high.
- mult_rst_n  out  1  active-low multiplier abort reset; tied 1 without the optional feature.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_product  out  16  captured product.
- out_err  out  1  result is an aborted job; always 0 without the optional feature.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_count  out  AW+1  current FIFO occupancy.

Behaviour:
Reset (rst low, asynchronous):
- FIFO empty.
- FSM in IDLE.
- mult_start=0, mult_a=0, mult_b=0, mult_rst_n=1.
- out_valid=0, out_product=0, out_err=0, busy=0, fifo_count=0.

FIFO:
- in_ready = (fifo_count != DEPTH).
- Push and pop in the same cycle leave the count unchanged and are legal when full or empty.
- Pointers wrap modulo DEPTH.

FSM states: IDLE, LOAD, RUN, HOLD.
- IDLE: if FIFO non-empty and the output slot is free (!out_valid, or out_valid && out_ready this cycle), pop the head into mult_a/mult_b and go to LOAD.
- LOAD: assert mult_start, go to RUN. Operands are therefore stable at least one cycle before start.
- RUN: mult_start stays 1 and operands are frozen.
  - On mult_done=1: deassert mult_start at that same edge, capture mult_product into out_product, set out_valid=1 and out_err=0, go to HOLD.
  - Deasserting on the done edge is mandatory; the multiplier restarts if start remains high after done.
- HOLD: one cycle with mult_start=0 so the multiplier settles in its idle state, then go to IDLE.

Output:
- out_valid clears on an out_ready handshake.
- Capture and handshake never coincide, because launch requires a free slot.

Timing:
- Latency from FIFO push to mult_start high is 3 cycles when idle and the slot is free.
- Back-to-back job spacing is multiplier latency + 3 cycles.

Boundary conditions:
- mult_done while not in RUN: ignored; no capture.
- out_ready held low: the FSM waits in IDLE and the FIFO keeps accepting until full.
- Reset mid-RUN: everything returns to reset values immediately; the in-flight job is discarded.

Optional Feature:
MULT_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT without mult_done: drop mult_start, drive mult_rst_n=0 for exactly one cycle, load out_product=0 with out_valid=1 and out_err=1, go to HOLD.
  - A mult_done arriving in the same cycle the counter reaches TIMEOUT wins: normal capture, no error.
- Undefined:
  - No counter; RUN waits indefinitely.
  - mult_rst_n constant 1, out_err constant 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, LOAD=1, RUN=2, HOLD=3).
  - Operand width (8) and product width (16) constants.
  - Default TIMEOUT.
- One natural sub-module, sync_fifo_op, is a parameterised DEPTH x 16-bit synchronous FIFO with count output, instantiated once for {a,b}.

Test Plan:
- Single job A=3, B=5, using a bench multiplier model with 20-cycle latency → mult_start high 3 cycles after push; out_product=0x000F, out_err=0; mult_start low on the done edge.
- A=-2 (0xFE), B=7 → out_product=0xFFF2.
- Push 5 pairs with out_ready=1 and DEPTH=4 → in_ready low once 4 are queued; all 5 results emerge in order; fifo_count returns to 0.
- out_ready=0 after the first result → no second mult_start until out_ready pulses; out_product holds its value.
- Assert rst low in the 10th RUN cycle → mult_start=0 and out_valid=0 immediately; a later job A=4, B=4 yields 0x0010.
- MULT_TIMEOUT_EN defined, model never returns done → after 31 RUN cycles: mult_rst_n low for 1 cycle, out_valid=1, out_err=1, out_product=0; the next job completes normally.
